fetch_stage: RTL

//  IF stage of the 5-stage LoongArch32 pipeline; producer of the fs->ds bus, consumer of ID's br_bus/ds_allowin.

---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/fetch_stage.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared widths, reset vector and state encoding for the IF stage and its neighbours.
package fetch_stage_pkg;

  localparam int          FS_TO_DS_BUS_WD = 64;
  localparam int          BR_BUS_WD       = 33;
  localparam logic [31:0] DEF_RESET_PC    = 32'h1c00_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } fs_state_e;

endpackage

// File: rtl/fetch_stage.sv
// IF stage: one-outstanding fetch over an SRAM-like port, a single instruction buffer
// handed to ID under valid/allowin, and squashing of wrong-path fetches on redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_req,
  output logic                       inst_sram_wr,
  output logic [1:0]                 inst_sram_size,
  output logic [3:0]                 inst_sram_wstrb,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata
);

  fs_state_e   state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;

  logic        br_taken;
  logic [31:0] br_target;
  logic        redirect;
  logic [31:0] req_addr;

  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];
  // Operands are only final when the branch actually leaves ID.
  assign redirect  = br_taken & ds_allowin;

  // A squashed request that is still waiting for addr_ok keeps its address in req_pc_q,
  // while fetch_pc_q already points at the branch target.
  assign req_addr  = discard_q ? req_pc_q : fetch_pc_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inst_q     <= '0;
      pc_q       <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    discard_d  = discard_q;

    unique case (state_q)
      S_REQ: begin
        if (inst_sram_addr_ok || redirect) begin
          req_pc_d = req_addr;
        end
        if (inst_sram_addr_ok) begin
          state_d = S_WAIT;
        end
        if (redirect) begin
          fetch_pc_d = br_target;
          discard_d  = 1'b1;
        end
      end

      S_WAIT: begin
        if (inst_sram_data_ok) begin
          state_d   = S_REQ;
          discard_d = 1'b0;
          if (!discard_q && !redirect) begin
            inst_d     = inst_sram_rdata;
            pc_d       = req_pc_q;
            fetch_pc_d = req_pc_q + 32'd4;
            state_d    = S_FULL;
          end
        end
        if (redirect) begin
          fetch_pc_d = br_target;
          if (!inst_sram_data_ok) begin
            discard_d = 1'b1;
          end
        end
      end

      S_FULL: begin
        if (redirect) begin
          fetch_pc_d = br_target;
          state_d    = S_REQ;
        end else if (ds_allowin) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_comb begin
    inst_sram_req  = (state_q == S_REQ) && !reset;
    inst_sram_addr = req_addr;
    fs_to_ds_valid = (state_q == S_FULL);
    fs_to_ds_bus   = {inst_q, pc_q};
  end

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'h0;

endmodule
